// File: rtl/axi32_pkg.sv
// axi32 shared definitions: response codes,
// master state encoding and a width helper.
package axi32_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } state_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi32_watchdog.sv
// axi32 per-transaction watchdog counter.
// Cleared on accept, counts while enabled.
module axi32_watchdog
  import axi32_pkg::*;
#(
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int cw = clogb2(timeout_cycles + 1);
  // fire early enough that the abort response
  // lands timeout_cycles cycles after accept
  localparam int lim =
    (timeout_cycles > 2) ? timeout_cycles - 2 : 0;

  logic [cw-1:0] cnt;

  assign expire = enable && (cnt >= cw'(lim));

  // clear on accept, count in-flight cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + cw'(1);
    end
  end

endmodule

// File: rtl/axi32_lite_master.sv
// axi32 single-outstanding AXI4-Lite master
// with watchdog abort of stuck transactions.
module axi32_lite_master
  import axi32_pkg::*;
#(
  parameter int datawidth      = 32,
  parameter int addrwidth      = 8,
  parameter int timeout_cycles = 255
) (
  input  logic                   m_axi_clk_in,
  input  logic                   m_axi_reset_n_in,
  input  logic                   req_valid_in,
  output logic                   req_ready_out,
  input  logic                   req_wr_in,
  input  logic [addrwidth-1:0]   req_addr_in,
  input  logic [datawidth-1:0]   req_wdata_in,
  input  logic [datawidth/8-1:0] req_wstrb_in,
  output logic                   rsp_valid_out,
  output logic [datawidth-1:0]   rsp_rdata_out,
  output logic [1:0]             rsp_resp_out,
  output logic                   rsp_timeout_out,
  output logic [addrwidth-1:0]   m_axi_awaddr_out,
  output logic                   m_axi_awvalid_out,
  input  logic                   m_axi_awready_in,
  output logic [datawidth-1:0]   m_axi_wdata_out,
  output logic [datawidth/8-1:0] m_axi_wstrb_out,
  output logic                   m_axi_wvalid_out,
  input  logic                   m_axi_wready_in,
  input  logic [1:0]             m_axi_bresp_in,
  input  logic                   m_axi_bvalid_in,
  output logic                   m_axi_bready_out,
  output logic [addrwidth-1:0]   m_axi_araddr_out,
  output logic                   m_axi_arvalid_out,
  input  logic                   m_axi_arready_in,
  input  logic [datawidth-1:0]   m_axi_rdata_in,
  input  logic [1:0]             m_axi_rresp_in,
  input  logic                   m_axi_rvalid_in,
  output logic                   m_axi_rready_out
);

  state_t state;
  logic   wd_load;
  logic   wd_en;
  logic   wd_expire;
  logic   aw_done;
  logic   w_done;

  assign wd_load = (state == ST_IDLE)
                && req_valid_in && req_ready_out;
  assign wd_en   = state inside {ST_WR, ST_WR_RESP,
                                 ST_RD_ADDR, ST_RD_DATA};
  assign aw_done = !m_axi_awvalid_out
                || m_axi_awready_in;
  assign w_done  = !m_axi_wvalid_out
                || m_axi_wready_in;

  axi32_watchdog #(
    .timeout_cycles(timeout_cycles)
  ) u_wd (
    .clk   (m_axi_clk_in),
    .rst_n (m_axi_reset_n_in),
    .load  (wd_load),
    .enable(wd_en),
    .expire(wd_expire)
  );

  // transaction sequencer with registered outputs
  always_ff @(posedge m_axi_clk_in
              or negedge m_axi_reset_n_in) begin
    if (!m_axi_reset_n_in) begin
      state             <= ST_IDLE;
      req_ready_out     <= 1'b0;
      rsp_valid_out     <= 1'b0;
      rsp_rdata_out     <= '0;
      rsp_resp_out      <= RESP_OKAY;
      rsp_timeout_out   <= 1'b0;
      m_axi_awaddr_out  <= '0;
      m_axi_awvalid_out <= 1'b0;
      m_axi_wdata_out   <= '0;
      m_axi_wstrb_out   <= '0;
      m_axi_wvalid_out  <= 1'b0;
      m_axi_bready_out  <= 1'b0;
      m_axi_araddr_out  <= '0;
      m_axi_arvalid_out <= 1'b0;
      m_axi_rready_out  <= 1'b0;
    end else begin
      rsp_valid_out <= 1'b0;
      if (wd_expire) begin
        // deliberate protocol break to recover
        m_axi_awvalid_out <= 1'b0;
        m_axi_wvalid_out  <= 1'b0;
        m_axi_bready_out  <= 1'b0;
        m_axi_arvalid_out <= 1'b0;
        m_axi_rready_out  <= 1'b0;
        rsp_rdata_out     <= '0;
        rsp_resp_out      <= RESP_SLVERR;
        rsp_timeout_out   <= 1'b1;
        rsp_valid_out     <= 1'b1;
        state             <= ST_RESP;
      end else begin
        unique case (state)
          ST_IDLE: begin
            req_ready_out <= 1'b1;
            if (req_valid_in && req_ready_out) begin
              req_ready_out <= 1'b0;
              if (req_wr_in) begin
                m_axi_awaddr_out  <= req_addr_in;
                m_axi_wdata_out   <= req_wdata_in;
                m_axi_wstrb_out   <= req_wstrb_in;
                m_axi_awvalid_out <= 1'b1;
                m_axi_wvalid_out  <= 1'b1;
                state             <= ST_WR;
              end else begin
                m_axi_araddr_out  <= req_addr_in;
                m_axi_arvalid_out <= 1'b1;
                state             <= ST_RD_ADDR;
              end
            end
          end
          ST_WR: begin
            if (m_axi_awready_in)
              m_axi_awvalid_out <= 1'b0;
            if (m_axi_wready_in)
              m_axi_wvalid_out <= 1'b0;
            if (aw_done && w_done) begin
              m_axi_bready_out <= 1'b1;
              state            <= ST_WR_RESP;
            end
          end
          ST_WR_RESP: begin
            if (m_axi_bvalid_in) begin
              m_axi_bready_out <= 1'b0;
              rsp_rdata_out    <= '0;
              rsp_resp_out     <= m_axi_bresp_in;
              rsp_timeout_out  <= 1'b0;
              rsp_valid_out    <= 1'b1;
              state            <= ST_RESP;
            end
          end
          ST_RD_ADDR: begin
            if (m_axi_arready_in) begin
              m_axi_arvalid_out <= 1'b0;
              m_axi_rready_out  <= 1'b1;
              state             <= ST_RD_DATA;
            end
          end
          ST_RD_DATA: begin
            if (m_axi_rvalid_in) begin
              m_axi_rready_out <= 1'b0;
              rsp_rdata_out    <= m_axi_rdata_in;
              rsp_resp_out     <= m_axi_rresp_in;
              rsp_timeout_out  <= 1'b0;
              rsp_valid_out    <= 1'b1;
              state            <= ST_RESP;
            end
          end
          ST_RESP: begin
            req_ready_out <= 1'b1;
            state         <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi32_lite_master.sv
// axi32_lite_master bench: directed and random
// transactions against a memory-backed slave.
module tb_axi32_lite_master;

  logic        m_axi_clk_in = 1'b0;
  logic        m_axi_reset_n_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_wr_in;
  logic [7:0]  req_addr_in;
  logic [31:0] req_wdata_in;
  logic [3:0]  req_wstrb_in;
  logic        rsp_valid_out;
  logic [31:0] rsp_rdata_out;
  logic [1:0]  rsp_resp_out;
  logic        rsp_timeout_out;
  logic [7:0]  m_axi_awaddr_out;
  logic        m_axi_awvalid_out;
  logic        m_axi_awready_in;
  logic [31:0] m_axi_wdata_out;
  logic [3:0]  m_axi_wstrb_out;
  logic        m_axi_wvalid_out;
  logic        m_axi_wready_in;
  logic [1:0]  m_axi_bresp_in;
  logic        m_axi_bvalid_in;
  logic        m_axi_bready_out;
  logic [7:0]  m_axi_araddr_out;
  logic        m_axi_arvalid_out;
  logic        m_axi_arready_in;
  logic [31:0] m_axi_rdata_in;
  logic [1:0]  m_axi_rresp_in;
  logic        m_axi_rvalid_in;
  logic        m_axi_rready_out;

  int n_err = 0;
  int n_chk = 0;

  // slave storage and reference storage
  logic [31:0] smem [64];
  logic [31:0] rmem [64];

  always #5 m_axi_clk_in = ~m_axi_clk_in;

  axi32_lite_master #(
    .datawidth     (32),
    .addrwidth     (8),
    .timeout_cycles(16)
  ) dut (
    .m_axi_clk_in     (m_axi_clk_in),
    .m_axi_reset_n_in (m_axi_reset_n_in),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .req_wr_in        (req_wr_in),
    .req_addr_in      (req_addr_in),
    .req_wdata_in     (req_wdata_in),
    .req_wstrb_in     (req_wstrb_in),
    .rsp_valid_out    (rsp_valid_out),
    .rsp_rdata_out    (rsp_rdata_out),
    .rsp_resp_out     (rsp_resp_out),
    .rsp_timeout_out  (rsp_timeout_out),
    .m_axi_awaddr_out (m_axi_awaddr_out),
    .m_axi_awvalid_out(m_axi_awvalid_out),
    .m_axi_awready_in (m_axi_awready_in),
    .m_axi_wdata_out  (m_axi_wdata_out),
    .m_axi_wstrb_out  (m_axi_wstrb_out),
    .m_axi_wvalid_out (m_axi_wvalid_out),
    .m_axi_wready_in  (m_axi_wready_in),
    .m_axi_bresp_in   (m_axi_bresp_in),
    .m_axi_bvalid_in  (m_axi_bvalid_in),
    .m_axi_bready_out (m_axi_bready_out),
    .m_axi_araddr_out (m_axi_araddr_out),
    .m_axi_arvalid_out(m_axi_arvalid_out),
    .m_axi_arready_in (m_axi_arready_in),
    .m_axi_rdata_in   (m_axi_rdata_in),
    .m_axi_rresp_in   (m_axi_rresp_in),
    .m_axi_rvalid_in  (m_axi_rvalid_in),
    .m_axi_rready_out (m_axi_rready_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready_in = 1'b0;
    m_axi_wready_in  = 1'b0;
    m_axi_bvalid_in  = 1'b0;
    m_axi_bresp_in   = 2'b00;
    m_axi_arready_in = 1'b0;
    m_axi_rvalid_in  = 1'b0;
    m_axi_rdata_in   = 32'h0;
    m_axi_rresp_in   = 2'b00;
  endtask

  // one request, called and returning on a negedge
  task automatic do_txn(input logic wr,
                        input logic [7:0] addr,
                        input logic [31:0] wd,
                        input logic [3:0] ws,
                        input int aw_lat,
                        input int w_lat,
                        input int ar_lat,
                        input logic b_en,
                        input logic [1:0] sresp,
                        input string tag);
    int k;
    int awc;
    int wc;
    int exp_lat;
    logic done;
    logic [5:0] idx;
    logic [5:0] sidx;
    logic [31:0] exp_rd;
    logic [1:0] exp_resp;
    logic exp_tmo;
    idx = addr[7:2];
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) rmem[idx][8*b +: 8] = wd[8*b +: 8];
      exp_rd   = 32'h0;
      if (b_en) begin
        exp_lat  = 3 + ((aw_lat > w_lat) ? aw_lat : w_lat);
        exp_resp = sresp;
        exp_tmo  = 1'b0;
      end else begin
        exp_lat  = 16;
        exp_resp = 2'b10;
        exp_tmo  = 1'b1;
      end
    end else begin
      exp_lat  = 3 + ar_lat;
      exp_rd   = rmem[idx];
      exp_resp = sresp;
      exp_tmo  = 1'b0;
    end
    chk({tag, " req_ready"}, 32'(req_ready_out), 32'd1);
    req_valid_in = 1'b1;
    req_wr_in    = wr;
    req_addr_in  = addr;
    req_wdata_in = wd;
    req_wstrb_in = ws;
    @(posedge m_axi_clk_in);
    #1 req_valid_in = 1'b0;
    k = 0; awc = 0; wc = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(negedge m_axi_clk_in);
      k++;
      if (rsp_valid_out) begin
        done = 1'b1;
      end else begin
        if (m_axi_awvalid_out) awc++;
        if (m_axi_wvalid_out) wc++;
        m_axi_awready_in = m_axi_awvalid_out
                        && (k >= 1 + aw_lat);
        m_axi_wready_in  = m_axi_wvalid_out
                        && (k >= 1 + w_lat);
        if (m_axi_awready_in)
          chk({tag, " awaddr"},
              32'(m_axi_awaddr_out), 32'(addr));
        if (m_axi_wready_in) begin
          chk({tag, " wdata"}, m_axi_wdata_out, wd);
          chk({tag, " wstrb"},
              32'(m_axi_wstrb_out), 32'(ws));
          sidx = m_axi_awaddr_out[7:2];
          for (int b = 0; b < 4; b++)
            if (m_axi_wstrb_out[b])
              smem[sidx][8*b +: 8] =
                m_axi_wdata_out[8*b +: 8];
        end
        m_axi_bvalid_in  = b_en && m_axi_bready_out;
        m_axi_bresp_in   = sresp;
        m_axi_arready_in = m_axi_arvalid_out
                        && (k >= 1 + ar_lat);
        if (m_axi_arready_in)
          chk({tag, " araddr"},
              32'(m_axi_araddr_out), 32'(addr));
        m_axi_rvalid_in = m_axi_rready_out;
        m_axi_rdata_in  = smem[m_axi_araddr_out[7:2]];
        m_axi_rresp_in  = sresp;
      end
    end
    slave_idle();
    chk({tag, " rsp_seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(k), 32'(exp_lat));
    chk({tag, " rdata"}, rsp_rdata_out, exp_rd);
    chk({tag, " resp"},
        32'(rsp_resp_out), 32'(exp_resp));
    chk({tag, " timeout"},
        32'(rsp_timeout_out), 32'(exp_tmo));
    if (wr) begin
      chk({tag, " aw_cycles"}, 32'(awc), 32'(aw_lat + 1));
      chk({tag, " w_cycles"}, 32'(wc), 32'(w_lat + 1));
      chk({tag, " bready_resp"},
          32'(m_axi_bready_out), 32'd0);
    end
    @(negedge m_axi_clk_in);
    chk({tag, " pulse_end"}, 32'(rsp_valid_out), 32'd0);
    chk({tag, " ready_back"}, 32'(req_ready_out), 32'd1);
    chk({tag, " rdata_held"}, rsp_rdata_out, exp_rd);
  endtask

  initial begin
    logic        rw;
    logic [5:0]  ri;
    logic [31:0] rd;
    logic [3:0]  rs;
    logic [1:0]  rr;
    int          l0;
    int          l1;
    int          l2;
    for (int i = 0; i < 64; i++) begin
      smem[i] = 32'h1000_0000 + 32'(i * 4);
      rmem[i] = smem[i];
    end
    smem[0] = 32'h5446_0000;
    rmem[0] = 32'h5446_0000;
    m_axi_reset_n_in = 1'b0;
    req_valid_in = 1'b0;
    req_wr_in    = 1'b0;
    req_addr_in  = 8'h0;
    req_wdata_in = 32'h0;
    req_wstrb_in = 4'h0;
    slave_idle();
    repeat (3) @(negedge m_axi_clk_in);
    chk("rst req_ready", 32'(req_ready_out), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("rst valids", 32'({m_axi_awvalid_out,
        m_axi_wvalid_out, m_axi_bready_out,
        m_axi_arvalid_out, m_axi_rready_out}), 32'd0);
    chk("rst rsp", 32'({rsp_resp_out, rsp_timeout_out,
        rsp_rdata_out}), 32'd0);
    m_axi_reset_n_in = 1'b1;
    @(negedge m_axi_clk_in);
    chk("rel req_ready", 32'(req_ready_out), 32'd1);

    do_txn(1'b1, 8'h04, 32'hA5A5_1234, 4'b0011,
           0, 0, 0, 1'b1, 2'b00, "wr_fast");
    do_txn(1'b1, 8'h20, 32'hDEAD_BEEF, 4'b1111,
           2, 0, 0, 1'b1, 2'b00, "wr_aw_late");
    do_txn(1'b0, 8'h00, 32'h0, 4'h0,
           0, 0, 0, 1'b1, 2'b00, "rd_00");
    do_txn(1'b0, 8'h0C, 32'h0, 4'h0,
           0, 0, 1, 1'b1, 2'b11, "rd_0c");
    do_txn(1'b1, 8'h30, 32'h0BAD_F00D, 4'b0101,
           0, 0, 0, 1'b0, 2'b00, "wr_tmo");
    do_txn(1'b1, 8'h34, 32'h1234_5678, 4'b1000,
           1, 3, 0, 1'b1, 2'b00, "wr_after_tmo");
    do_txn(1'b0, 8'h30, 32'h0, 4'h0,
           0, 0, 2, 1'b1, 2'b00, "rd_30");
    do_txn(1'b0, 8'h04, 32'h0, 4'h0,
           0, 0, 0, 1'b1, 2'b00, "rd_04");

    for (int n = 0; n < 16; n++) begin
      rw = 1'($urandom_range(0, 1));
      ri = 6'($urandom_range(0, 15));
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      rr = 2'($urandom_range(0, 3));
      l0 = int'($urandom_range(0, 3));
      l1 = int'($urandom_range(0, 3));
      l2 = int'($urandom_range(0, 3));
      do_txn(rw, {ri, 2'b00}, rd, rs, l0, l1, l2,
             1'b1, rr, $sformatf("rnd%0d", n));
    end

    req_valid_in = 1'b1;
    req_wr_in    = 1'b0;
    req_addr_in  = 8'h10;
    @(posedge m_axi_clk_in);
    #1 req_valid_in = 1'b0;
    @(negedge m_axi_clk_in);
    chk("rrst arvalid", 32'(m_axi_arvalid_out), 32'd1);
    m_axi_arready_in = m_axi_arvalid_out;
    @(negedge m_axi_clk_in);
    m_axi_arready_in = 1'b0;
    chk("rrst in_rd_data", 32'(m_axi_rready_out), 32'd1);
    #2 m_axi_reset_n_in = 1'b0;
    #1;
    chk("rrst async arvalid",
        32'(m_axi_arvalid_out), 32'd0);
    chk("rrst async rready",
        32'(m_axi_rready_out), 32'd0);
    chk("rrst async rsp_valid",
        32'(rsp_valid_out), 32'd0);
    repeat (2) begin
      @(negedge m_axi_clk_in);
      chk("rrst no_rsp", 32'(rsp_valid_out), 32'd0);
    end
    m_axi_reset_n_in = 1'b1;
    @(negedge m_axi_clk_in);
    chk("rrst ready_after",
        32'(req_ready_out), 32'd1);
    chk("rrst no_rsp_after",
        32'(rsp_valid_out), 32'd0);
    do_txn(1'b0, 8'h00, 32'h0, 4'h0,
           0, 0, 0, 1'b1, 2'b00, "rd_post_rst");

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
